reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all channels, release them one by one, then supervise with a watchdog.
// Outputs are registered; SoftReset restarts the sequence without touching CycleCount or Timeout.
module reset_sequencer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGE_GAP      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int AUTO_RESTART   = 0,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    soft_reset_i,
    input  logic                    heartbeat_i,
    output logic [NUM_CHANNELS-1:0] channel_reset_o,
    output logic                    all_released_o,
    output logic [CNT_WIDTH-1:0]    cycle_count_o,
    output logic                    timeout_o,
    output logic [1:0]              state_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int IDX_W  = $clog2(NUM_CHANNELS + 1);
    localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 32) begin : g_bad_channels
        $error("reset_sequencer: NUM_CHANNELS must be in 1..32");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be at least 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("reset_sequencer: STAGE_GAP must be at least 1");
    end
    if (TIMEOUT_CYCLES < 0) begin : g_bad_timeout
        $error("reset_sequencer: TIMEOUT_CYCLES must not be negative");
    end
    if (AUTO_RESTART != 0 && AUTO_RESTART != 1) begin : g_bad_auto
        $error("reset_sequencer: AUTO_RESTART must be 0 or 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("reset_sequencer: CNT_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [NUM_CHANNELS-1:0] chan_q, chan_d;
    logic                    all_q, all_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]    cycle_q, cycle_d;

    logic [HOLD_W-1:0] hold_inc;
    logic [GAP_W-1:0]  gap_inc;
    logic [WD_W-1:0]   wd_inc;

    assign hold_inc = hold_q + HOLD_W'(1);
    assign gap_inc  = gap_q + GAP_W'(1);
    assign wd_inc   = wd_q + WD_W'(1);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        wd_d      = '0;
        chan_d    = chan_q;
        all_d     = all_q;
        timeout_d = timeout_q;
        cycle_d   = cycle_q + CNT_WIDTH'(1);

        if (soft_reset_i) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
            chan_d  = '1;
            all_d   = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    chan_d = '1;
                    all_d  = 1'b0;
                    if (hold_inc == HOLD_W'(HOLD_CYCLES)) begin
                        chan_d[0] = 1'b0;
                        hold_d    = '0;
                        gap_d     = '0;
                        idx_d     = IDX_W'(1);
                        state_d   = ST_RELEASE;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                ST_RELEASE: begin
                    // idx_q counts channels already released; RUN follows one edge after the last
                    if (idx_q == IDX_W'(NUM_CHANNELS)) begin
                        state_d = ST_RUN;
                        all_d   = 1'b1;
                        gap_d   = '0;
                    end else if (gap_inc == GAP_W'(STAGE_GAP)) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                chan_d[i] = 1'b0;
                            end
                        end
                        idx_d = idx_q + IDX_W'(1);
                        gap_d = '0;
                    end else begin
                        gap_d = gap_inc;
                    end
                end
                ST_RUN: begin
                    chan_d = '0;
                    all_d  = 1'b1;
                    if (heartbeat_i || TIMEOUT_CYCLES == 0) begin
                        wd_d = '0;
                    end else if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
                        timeout_d = 1'b1;
                        all_d     = 1'b0;
                        chan_d    = '1;
                        hold_d    = '0;
                        gap_d     = '0;
                        idx_d     = '0;
                        state_d   = (AUTO_RESTART != 0) ? ST_HOLD : ST_FAULT;
                    end else begin
                        wd_d = wd_inc;
                    end
                end
                default: begin
                    chan_d = '1;
                    all_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_HOLD;
            hold_q    <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            wd_q      <= '0;
            chan_q    <= '1;
            all_q     <= 1'b0;
            timeout_q <= 1'b0;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            wd_q      <= wd_d;
            chan_q    <= chan_d;
            all_q     <= all_d;
            timeout_q <= timeout_d;
            cycle_q   <= cycle_d;
        end
    end

    assign channel_reset_o = chan_q;
    assign all_released_o  = all_q;
    assign cycle_count_o   = cycle_q;
    assign timeout_o       = timeout_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Three differently parameterised sequencers share stimulus; each is checked every cycle against
// a timeline model (edges since sequence start, edges since last heartbeat) plus literal checkpoints.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sr  = 1'b0;
    logic hb  = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int e = 0;

    logic [3:0]  a_ch;  logic a_all; logic [3:0]  a_cnt; logic a_to; logic [1:0] a_st;
    logic [2:0]  b_ch;  logic b_all; logic [31:0] b_cnt; logic b_to; logic [1:0] b_st;
    logic [0:0]  c_ch;  logic c_all; logic [7:0]  c_cnt; logic c_to; logic [1:0] c_st;

    reset_sequencer #(.NUM_CHANNELS(4), .HOLD_CYCLES(16), .STAGE_GAP(4), .TIMEOUT_CYCLES(8),
                      .AUTO_RESTART(0), .CNT_WIDTH(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .soft_reset_i(sr), .heartbeat_i(hb),
        .channel_reset_o(a_ch), .all_released_o(a_all), .cycle_count_o(a_cnt),
        .timeout_o(a_to), .state_o(a_st));

    reset_sequencer #(.NUM_CHANNELS(3), .HOLD_CYCLES(5), .STAGE_GAP(2), .TIMEOUT_CYCLES(8),
                      .AUTO_RESTART(1), .CNT_WIDTH(32)) dut_b (
        .clk_i(clk), .rst_i(rst), .soft_reset_i(sr), .heartbeat_i(hb),
        .channel_reset_o(b_ch), .all_released_o(b_all), .cycle_count_o(b_cnt),
        .timeout_o(b_to), .state_o(b_st));

    reset_sequencer #(.NUM_CHANNELS(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .TIMEOUT_CYCLES(0),
                      .AUTO_RESTART(0), .CNT_WIDTH(8)) dut_c (
        .clk_i(clk), .rst_i(rst), .soft_reset_i(sr), .heartbeat_i(hb),
        .channel_reset_o(c_ch), .all_released_o(c_all), .cycle_count_o(c_cnt),
        .timeout_o(c_to), .state_o(c_st));

    typedef struct {
        int n; int hold; int gap; int to; int auto_r; int w;
    } cfg_t;

    // k: edges since the sequence last (re)started; wd: RUN edges since RUN entry or last heartbeat
    typedef struct {
        int k; bit fault; int wd; bit to; longint unsigned cyc;
    } mstate_t;

    cfg_t    cfg[3];
    mstate_t mdl[3];

    function automatic int run_at(cfg_t c);
        return c.hold + (c.n - 1) * c.gap + 1;
    endfunction

    function automatic mstate_t step(cfg_t c, mstate_t m, bit r, bit s, bit h);
        mstate_t x = m;
        if (r) begin
            x.k = 0; x.fault = 0; x.wd = 0; x.to = 0; x.cyc = 0;
            return x;
        end
        x.cyc = (m.cyc + 1) % (64'd1 << c.w);
        if (s) begin
            x.k = 0; x.fault = 0; x.wd = 0;
            return x;
        end
        if (m.fault) return x;
        if (m.k >= run_at(c)) begin
            if (h) x.wd = 0;
            else if (c.to != 0 && m.wd + 1 == c.to) begin
                x.to = 1; x.wd = 0;
                if (c.auto_r != 0) x.k = 0;
                else x.fault = 1;
            end else x.wd = m.wd + 1;
        end else begin
            x.k = m.k + 1;
        end
        return x;
    endfunction

    function automatic int exp_state(cfg_t c, mstate_t m);
        if (m.fault) return 3;
        if (m.k >= run_at(c)) return 2;
        if (m.k >= c.hold) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] exp_chan(cfg_t c, mstate_t m);
        logic [31:0] v = '0;
        for (int i = 0; i < c.n; i++)
            v[i] = m.fault || (m.k < c.hold + i * c.gap);
        return v;
    endfunction

    function automatic bit exp_all(cfg_t c, mstate_t m);
        return !m.fault && m.k >= run_at(c);
    endfunction

    function automatic logic [31:0] d_chan(int i);
        case (i)
            0: return 32'(a_ch);
            1: return 32'(b_ch);
            default: return 32'(c_ch);
        endcase
    endfunction
    function automatic logic [31:0] d_cnt(int i);
        case (i)
            0: return 32'(a_cnt);
            1: return b_cnt;
            default: return 32'(c_cnt);
        endcase
    endfunction
    function automatic logic [1:0] d_st(int i);
        case (i)
            0: return a_st;
            1: return b_st;
            default: return c_st;
        endcase
    endfunction
    function automatic logic d_all(int i);
        case (i)
            0: return a_all;
            1: return b_all;
            default: return c_all;
        endcase
    endfunction
    function automatic logic d_to(int i);
        case (i)
            0: return a_to;
            1: return b_to;
            default: return c_to;
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp);
        end
    endtask

    // Model stepped on each rising edge, compared on the following falling edge.
    initial begin
        cfg[0] = '{n: 4, hold: 16, gap: 4, to: 8, auto_r: 0, w: 4};
        cfg[1] = '{n: 3, hold: 5,  gap: 2, to: 8, auto_r: 1, w: 32};
        cfg[2] = '{n: 1, hold: 1,  gap: 1, to: 0, auto_r: 0, w: 8};
        for (int i = 0; i < 3; i++) mdl[i] = '{k: 0, fault: 0, wd: 0, to: 0, cyc: 0};
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) mdl[i] = step(cfg[i], mdl[i], rst, sr, hb);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_state[%0d]", i), d_st(i), exp_state(cfg[i], mdl[i]));
                chk($sformatf("model_chan[%0d]", i), d_chan(i), exp_chan(cfg[i], mdl[i]));
                chk($sformatf("model_all[%0d]", i), d_all(i), exp_all(cfg[i], mdl[i]));
                chk($sformatf("model_timeout[%0d]", i), d_to(i), mdl[i].to);
                chk($sformatf("model_count[%0d]", i), d_cnt(i), mdl[i].cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic restart();
        rst = 1'b1; sr = 1'b0; hb = 1'b0;
        tick();
        rst = 1'b0;
        e = 0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_a_state", a_st, 0);
        chk("rst_a_chan", a_ch, 4'hF);
        chk("rst_a_all", a_all, 0);
        chk("rst_a_count", a_cnt, 0);
        chk("rst_a_timeout", a_to, 0);
        chk("rst_b_chan", b_ch, 3'h7);

        // Release sequence, wrap of a 4-bit counter, then watchdog expiry with no heartbeat.
        rst = 1'b0; e = 0;
        for (int n = 1; n <= 137; n++) begin
            tick();
            if (e == 1)   chk("c_bit0_edge1", c_ch, 0);
            if (e == 2)   chk("c_run_edge2", c_st, 2);
            if (e == 15)  begin chk("a_cnt_15", a_cnt, 15); chk("a_chan_e15", a_ch, 4'hF); end
            if (e == 16)  begin chk("a_cnt_wrap", a_cnt, 0); chk("a_chan_e16", a_ch, 4'b1110); end
            if (e == 18)  begin chk("b_autorst_state", b_st, 0); chk("b_autorst_to", b_to, 1);
                                chk("b_autorst_chan", b_ch, 3'h7); end
            if (e == 20)  chk("a_chan_e20", a_ch, 4'b1100);
            if (e == 22)  chk("b_chan_e22", b_ch, 3'h7);
            if (e == 23)  begin chk("b_rerelease", b_ch, 3'b110); chk("b_to_sticky", b_to, 1); end
            if (e == 24)  chk("a_chan_e24", a_ch, 4'b1000);
            if (e == 28)  begin chk("a_chan_e28", a_ch, 4'b0000); chk("a_state_e28", a_st, 1);
                                chk("a_all_e28", a_all, 0); end
            if (e == 29)  begin chk("a_state_e29", a_st, 2); chk("a_all_e29", a_all, 1);
                                chk("model_a_state_e29", exp_state(cfg[0], mdl[0]), 2); end
            if (e == 36)  chk("a_to_e36", a_to, 0);
            if (e == 37)  begin chk("a_to_e37", a_to, 1); chk("a_state_e37", a_st, 3);
                                chk("a_chan_e37", a_ch, 4'hF); chk("a_all_e37", a_all, 0);
                                chk("model_a_fault_e37", exp_state(cfg[0], mdl[0]), 3); end
            if (e == 137) begin chk("a_fault_hold_st", a_st, 3); chk("a_fault_hold_ch", a_ch, 4'hF);
                                chk("a_fault_hold_to", a_to, 1); end
        end

        // Heartbeat on each would-be expiry edge keeps the watchdog quiet.
        restart();
        for (int n = 1; n <= 1029; n++) begin
            hb = (e + 1 > 29) && ((e + 1 - 29) % 8 == 0);
            tick();
        end
        hb = 1'b0;
        chk("a_hb_no_timeout", a_to, 0);
        chk("a_hb_still_run", a_st, 2);

        // SoftReset mid-release restarts the hold, counter keeps going.
        restart();
        for (int n = 1; n <= 40; n++) begin
            sr = (e + 1 == 22);
            tick();
            if (e == 22) begin chk("sr_chan_e22", a_ch, 4'hF); chk("sr_state_e22", a_st, 0);
                               chk("sr_cnt_e22", a_cnt, 6); end
            if (e == 37) chk("sr_chan_e37", a_ch, 4'hF);
            if (e == 38) begin chk("sr_chan_e38", a_ch, 4'b1110); chk("sr_cnt_e38", a_cnt, 6); end
        end
        sr = 1'b0;

        // Reset while running aborts immediately.
        restart();
        repeat (30) tick();
        chk("pre_rst_run", a_st, 2);
        rst = 1'b1;
        tick();
        chk("rst_run_state", a_st, 0);
        chk("rst_run_chan", a_ch, 4'hF);
        chk("rst_run_all", a_all, 0);
        chk("rst_run_cnt", a_cnt, 0);
        rst = 1'b0; e = 0;

        // Random mix of heartbeats, soft resets and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            hb  = ($urandom_range(0, 5) == 0);
            sr  = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; sr = 1'b0; hb = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
